// File: rtl/spi_slave_core_pkg.sv
// Shared constants and types for the byte-wide SPI slave: states, SPI mode defaults,
// frame width and idle fill byte.
package spi_slave_core_pkg;

  localparam int unsigned FrameBits = 8;
  localparam logic [FrameBits-1:0] DefaultIdleFill = 8'hFF;

  // SPI mode 0 unless overridden per instance.
  localparam logic DefaultCpol = 1'b0;
  localparam logic DefaultCpha = 1'b0;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } spi_state_e;

  typedef logic [$clog2(FrameBits)-1:0] bitcnt_t;

  localparam bitcnt_t LastBit = bitcnt_t'(FrameBits - 1);

endpackage

// File: rtl/spi_slave_core_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus registered one-cycle strobes
// on rising and falling edges of the synchronised level.
module spi_slave_core_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;
  logic rise_q, fall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_core.sv
// Byte-wide SPI slave: oversamples SPI_CLK/MOSI/SS_N, deserialises MOSI into data_out_o
// and serialises a one-deep transmit holding register onto miso_o.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter logic                 Cpol     = DefaultCpol,
  parameter logic                 Cpha     = DefaultCpha,
  parameter logic [FrameBits-1:0] IdleFill = DefaultIdleFill
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 data_in_rdy_o,
  input  logic                 data_in_vd_i,
  input  logic [FrameBits-1:0] data_in_i,
  output logic [FrameBits-1:0] data_out_o,
  output logic                 data_out_vd_o,
  input  logic                 spi_clk_i,
  input  logic                 mosi_i,
  output logic                 miso_o,
  input  logic                 ss_n_i
);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic mosi_meta_q, mosi_sync_q;

  spi_slave_core_sync_edge #(
    .ResetVal (Cpol)
  ) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_clk_i),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_slave_core_sync_edge #(
    .ResetVal (1'b1)
  ) u_sync_ss (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ss_n_i),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  spi_state_e           state_q;
  bitcnt_t              bitcnt_q;
  logic [FrameBits-2:0] rx_q;
  logic [FrameBits-1:0] tx_q, hold_q, data_out_q;
  logic                 hold_full_q, data_out_vd_q;

  logic lead, trail, samp, upd, active, cnt_zero;
  logic load_en, shift_en, samp_en, wr_en;

  assign lead     = Cpol ? sclk_fall : sclk_rise;
  assign trail    = Cpol ? sclk_rise : sclk_fall;
  assign samp     = Cpha ? trail : lead;
  assign upd      = Cpha ? lead : trail;
  assign active   = (state_q == StActive);
  assign cnt_zero = (bitcnt_q == '0);

  // CPHA=0 must present bit 7 before the first leading edge, so it also loads on select.
  assign load_en  = (!Cpha && !active && ss_fall) || (active && !ss_rise && upd && cnt_zero);
  assign shift_en = active && !ss_rise && upd && !cnt_zero;
  assign samp_en  = active && !ss_rise && samp;
  assign wr_en    = data_in_vd_i && !hold_full_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      bitcnt_q      <= '0;
      rx_q          <= '0;
      tx_q          <= IdleFill;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      data_out_q    <= '0;
      data_out_vd_q <= 1'b0;
    end else begin
      data_out_vd_q <= 1'b0;
      case (state_q)
        StIdle: begin
          bitcnt_q <= '0;
          if (ss_fall) state_q <= StActive;
        end
        StActive: begin
          if (ss_rise) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
          end else if (samp_en) begin
            rx_q     <= {rx_q[FrameBits-3:0], mosi_sync_q};
            bitcnt_q <= bitcnt_q + bitcnt_t'(1);
            if (bitcnt_q == LastBit) begin
              data_out_q    <= {rx_q, mosi_sync_q};
              data_out_vd_q <= 1'b1;
            end
          end
        end
      endcase

      if (load_en) begin
        tx_q        <= hold_full_q ? hold_q : IdleFill;
        hold_full_q <= 1'b0;
      end else if (shift_en) begin
        tx_q <= {tx_q[FrameBits-2:0], 1'b0};
      end

      // A write can only land while holding is empty, so it never collides with a load.
      if (wr_en) begin
        hold_q      <= data_in_i;
        hold_full_q <= 1'b1;
      end
    end
  end

  assign data_in_rdy_o = ~hold_full_q;
  assign data_out_o    = data_out_q;
  assign data_out_vd_o = data_out_vd_q;
  assign miso_o        = tx_q[FrameBits-1];

endmodule

// File: tb/tb_spi_slave_core.sv
// Randomised bench for spi_slave_core: a mode-0 and a mode-3 instance driven by a
// bit-banged master, checked against a frame-level holding-register model.
`timescale 1ns/1ps
module tb_spi_slave_core;

  logic       clk, rst_n;
  logic       sclk [2];
  logic       mosi [2];
  logic       ss_n [2];
  logic       din_vd [2];
  logic       rdy [2];
  logic       dout_vd [2];
  logic       miso [2];
  logic [7:0] din [2];
  logic [7:0] dout [2];

  int n_checks = 0;
  int n_errors = 0;
  int vd_cnt0 = 0;
  int vd_cnt1 = 0;

  // Model: one-deep holding register, byte queued for the current frame, last byte received.
  bit         hold_v [2];
  logic [7:0] hold_b [2];
  logic [7:0] frame_b [2];
  logic [7:0] last_rx [2];

  spi_slave_core #(.Cpol(1'b0), .Cpha(1'b0), .IdleFill(8'hFF)) u_dut0 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_in_rdy_o (rdy[0]),
    .data_in_vd_i  (din_vd[0]),
    .data_in_i     (din[0]),
    .data_out_o    (dout[0]),
    .data_out_vd_o (dout_vd[0]),
    .spi_clk_i     (sclk[0]),
    .mosi_i        (mosi[0]),
    .miso_o        (miso[0]),
    .ss_n_i        (ss_n[0])
  );

  spi_slave_core #(.Cpol(1'b1), .Cpha(1'b1), .IdleFill(8'hFF)) u_dut1 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_in_rdy_o (rdy[1]),
    .data_in_vd_i  (din_vd[1]),
    .data_in_i     (din[1]),
    .data_out_o    (dout[1]),
    .data_out_vd_o (dout_vd[1]),
    .spi_clk_i     (sclk[1]),
    .mosi_i        (mosi[1]),
    .miso_o        (miso[1]),
    .ss_n_i        (ss_n[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dout_vd[0] === 1'b1) vd_cnt0++;
  always @(negedge clk) if (dout_vd[1] === 1'b1) vd_cnt1++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int vd_count(input int i);
    return (i == 1) ? vd_cnt1 : vd_cnt0;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_load(input int i, output logic [7:0] b);
    b = hold_v[i] ? hold_b[i] : 8'hFF;
    hold_v[i] = 1'b0;
  endtask

  task automatic write_byte(input int i, input logic [7:0] b);
    din[i] = b;
    din_vd[i] = 1'b1;
    wait_clk(1);
    din_vd[i] = 1'b0;
    if (!hold_v[i]) begin
      hold_v[i] = 1'b1;
      hold_b[i] = b;
    end
    check("rdy_after_write", {31'b0, rdy[i]}, 32'd0);
  endtask

  task automatic select(input int i);
    ss_n[i] = 1'b0;
    wait_clk(8);
    if (i == 0) begin
      model_load(i, frame_b[i]);
      check("rdy_after_select_load", {31'b0, rdy[i]}, {31'b0, !hold_v[i]});
    end
  endtask

  task automatic deselect(input int i);
    ss_n[i] = 1'b1;
    wait_clk(8);
  endtask

  // Master side: 4 CLK per SPI_CLK phase; MISO sampled just before the slave's next update.
  task automatic spi_frame(input int i, input logic [7:0] tx, input int nbits,
                           input bit do_wr, input logic [7:0] wr_b);
    logic [7:0] got, exp;
    int         vd0;
    bit         cpha, cpol;
    cpha = (i == 1);
    cpol = (i == 1);
    got  = '0;
    vd0  = vd_count(i);
    if (cpha) model_load(i, exp);
    else exp = frame_b[i];
    for (int b = 0; b < nbits; b++) begin
      if (cpha && b > 0) got[8-b] = miso[i];
      mosi[i] = tx[7-b];
      sclk[i] = ~cpol;
      if (do_wr && b == 3) begin
        wait_clk(3);
        write_byte(i, wr_b);
      end else begin
        wait_clk(4);
      end
      if (!cpha) got[7-b] = miso[i];
      sclk[i] = cpol;
      wait_clk(4);
    end
    if (nbits == 8) begin
      if (cpha) begin
        wait_clk(4);
        got[0] = miso[i];
      end
      check("miso_byte", {24'b0, got}, {24'b0, exp});
      check("vd_pulses_full", vd_count(i) - vd0, 32'd1);
      check("data_out", {24'b0, dout[i]}, {24'b0, tx});
      last_rx[i] = tx;
      if (!cpha) model_load(i, frame_b[i]);
    end else begin
      wait_clk(4);
      check("vd_pulses_partial", vd_count(i) - vd0, 32'd0);
      check("data_out_kept", {24'b0, dout[i]}, {24'b0, last_rx[i]});
    end
  endtask

  task automatic check_reset_vals(input int i);
    check("rst_rdy", {31'b0, rdy[i]}, 32'd1);
    check("rst_data_out", {24'b0, dout[i]}, 32'd0);
    check("rst_vd", {31'b0, dout_vd[i]}, 32'd0);
    check("rst_miso", {31'b0, miso[i]}, 32'd1);
  endtask

  initial begin
    int         inst;
    int         nfr;
    rst_n = 1'b0;
    sclk[0] = 1'b0;
    sclk[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ss_n[i] = 1'b1;
      mosi[i] = 1'b0;
      din[i] = '0;
      din_vd[i] = 1'b0;
      hold_v[i] = 1'b0;
      hold_b[i] = '0;
      frame_b[i] = 8'hFF;
      last_rx[i] = '0;
    end
    wait_clk(3);
    check_reset_vals(0);
    check_reset_vals(1);
    rst_n = 1'b1;
    wait_clk(4);

    // Mode 0 basic transfer with a queued byte.
    write_byte(0, 8'hA5);
    select(0);
    spi_frame(0, 8'h3C, 8, 1'b0, 8'h00);
    deselect(0);

    // Nothing queued: idle fill goes out.
    select(0);
    spi_frame(0, 8'h00, 8, 1'b0, 8'h00);
    deselect(0);

    // Back-to-back frames; byte written during frame 1 goes out in frame 2.
    select(0);
    spi_frame(0, 8'h12, 8, 1'b1, 8'h56);
    spi_frame(0, 8'h34, 8, 1'b0, 8'h00);
    deselect(0);

    // Select dropped after 5 bits, then a full frame.
    select(0);
    spi_frame(0, 8'h5A, 5, 1'b0, 8'h00);
    deselect(0);
    select(0);
    spi_frame(0, 8'h81, 8, 1'b0, 8'h00);
    deselect(0);

    // CPOL=1, CPHA=1 instance.
    write_byte(1, 8'h81);
    select(1);
    spi_frame(1, 8'h7E, 8, 1'b0, 8'h00);
    deselect(1);

    // Reset in the middle of a frame with a byte held.
    select(0);
    spi_frame(0, 8'($urandom), 4, 1'b1, 8'hE7);
    rst_n = 1'b0;
    wait_clk(2);
    check_reset_vals(0);
    check_reset_vals(1);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hold_v[i] = 1'b0;
      last_rx[i] = '0;
    end
    deselect(0);
    select(0);
    spi_frame(0, 8'hC3, 8, 1'b0, 8'h00);
    deselect(0);

    // Random traffic on both instances.
    for (int k = 0; k < 12; k++) begin
      inst = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) write_byte(inst, 8'($urandom));
      select(inst);
      nfr = int'($urandom_range(1, 2));
      for (int f = 0; f < nfr; f++) begin
        spi_frame(inst, 8'($urandom), 8, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      deselect(inst);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Byte-wide SPI slave: the far end of the link driven by the SPI master core. Oversamples the external SPI_CLK, MOSI and SS_N pins in the system CLK domain, deserialises 8-bit MOSI frames into DATA_OUT, and serialises a byte from a one-deep transmit holding register onto MISO. The user-side handshake mirrors the master core's DATA_IN_VD/DATA_IN_RDY and DATA_OUT/DATA_OUT_VD, so the same user logic attaches to either end.

## Interface
- CPOL, 0, SPI_CLK idle level; leading edge = transition away from CPOL.
- CPHA, 0, 0: sample MOSI on leading edge, update MISO on trailing; 1: update MISO on leading edge, sample MOSI on trailing.
- IDLE_FILL, 8'hFF, byte shifted out when no transmit byte is held.
- CLK  in  1  system clock; all logic on rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- DATA_IN_RDY  out  1  transmit holding register empty.
- DATA_IN_VD  in  1  DATA_IN valid; write occurs when DATA_IN_VD & DATA_IN_RDY.
- DATA_IN  in  8  byte for the next frame, MSB first.
- DATA_OUT  out  8  last complete received byte.
- DATA_OUT_VD  out  1  one-CLK pulse: DATA_OUT updated.
- SPI_CLK  in  1  SPI clock from master, asynchronous.
- MOSI  in  1  serial data from master, asynchronous.
- MISO  out  1  serial data to master.
- SS_N  in  1  select, active-low, asynchronous; tie low for master without select.

## Operation
- SPI_CLK, MOSI, SS_N pass through 2-flop synchronisers; edge detect on synchronised SPI_CLK produces lead/trail strobes.
- States: IDLE (SS_N high) and ACTIVE (SS_N low). IDLE->ACTIVE on synchronised SS_N fall; ACTIVE->IDLE on rise. 3-bit counter BITCNT is reset to 0 in IDLE.
- Shift-register load (BITCNT==0): CPHA=0 on entry to ACTIVE and on the trailing edge that ends bit 7; CPHA=1 on the first leading edge of each frame. Load takes the holding register if full (holding then empties, DATA_IN_RDY rises next cycle), else IDLE_FILL.
- MISO = shift-register MSB; shifts left at each update edge other than a load edge.
- At each sample edge, the synchronised MOSI shifts into the RX register LSB and BITCNT increments, wrapping 7->0. On the 8th sample: DATA_OUT <= RX byte, DATA_OUT_VD pulses.
- With SS_N held low, frames run back-to-back purely by bit count.
- SS_N rise mid-frame: partial RX byte discarded, no DATA_OUT_VD, BITCNT=0; the byte already loaded is lost; the holding register is untouched.
- Write and load in the same cycle: write succeeds only if RDY was high (holding empty), so the load takes IDLE_FILL and the new byte stays in holding for the next frame.
- DATA_OUT is overwritten on every completed frame; the block has no overrun flag.

## Timing
- Reset values: DATA_IN_RDY=1, DATA_OUT=8'h00, DATA_OUT_VD=0, MISO=IDLE_FILL[7], state IDLE, BITCNT=0, holding empty.
- Pin-to-strobe latency: the edge strobe asserts on the 3rd CLK edge after the first CLK edge that samples a new pin level.
- DATA_OUT_VD asserts exactly 1 CLK after the 8th sample strobe, for 1 CLK.
- MISO changes 1 CLK after the update strobe. SPI_CLK high and low phases must each be at least 4 CLK.
- CPHA=0: the first MISO bit is valid 4 CLK after the SS_N fall at the pin; the master must not issue a leading edge sooner.
- RSTN low mid-frame: every register takes its reset value at the next CLK edge; the frame is abandoned.

## Structure
- Shared include spi_defs.vh: state encodings (IDLE/ACTIVE), SPI mode constants, default IDLE_FILL, frame width 8.
- Sub-module spi_sync_edge: 2-flop synchroniser plus rising/falling strobe, instantiated for SPI_CLK and SS_N; MOSI uses the synchroniser only.

## Test plan
- Mode 0, SPI_CLK period 8 CLK: DATA_IN=8'hA5 written, SS_N low, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; DATA_OUT=8'h3C with one DATA_OUT_VD pulse; DATA_IN_RDY 0 after the write, 1 after the load.
- No byte written, master sends 8'h00 -> MISO all ones (8'hFF), DATA_OUT=8'h00, VD pulses once.
- SS_N held low for two frames 8'h12, 8'h34; 8'h56 written during frame 1 -> frame 2 MISO=8'h56, DATA_OUT 8'h12 then 8'h34, two VD pulses.
- SS_N rises after 5 bits, then a full frame of 8'h81 -> no VD for the partial frame; next DATA_OUT=8'h81.
- CPOL=1, CPHA=1 instance: DATA_IN=8'h81, master sends 8'h7E -> MISO 8'h81, DATA_OUT=8'h7E.
- RSTN low for 2 CLK after bit 3 -> all outputs at reset values; next full frame 8'hC3 received correctly with one VD pulse.
